// File: rtl/fft8_twiddle_seq_pkg.sv
// Shared constants, state encoding and Q8.8 twiddle values for the 8-point FFT sequencer.
// The multiplier and reference models import the same twiddle constants from here.
package fft8_twiddle_seq_pkg;

    localparam int W_WIDTH  = 16;
    localparam int FRAC     = 8;
    localparam int STAGE_W  = 2;
    localparam int BFLY_W   = 2;
    localparam int IDX_W    = 3;
    localparam int K_W      = 2;
    localparam int N_STAGES = 3;
    localparam int N_BFLY   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic signed [W_WIDTH-1:0] q88_t;

    // W8^k = cos(2*pi*k/8) - j*sin(2*pi*k/8), truncated to Q8.8
    localparam q88_t TW0_RE = 16'sh0100;
    localparam q88_t TW0_IM = 16'sh0000;
    localparam q88_t TW1_RE = 16'sh00B5;
    localparam q88_t TW1_IM = 16'shFF4B;
    localparam q88_t TW2_RE = 16'sh0000;
    localparam q88_t TW2_IM = 16'shFF00;
    localparam q88_t TW3_RE = 16'shFF4B;
    localparam q88_t TW3_IM = 16'shFF4B;

    // k = (b & (2^s - 1)) << (2 - s), unrolled for the three legal stages
    function automatic logic [K_W-1:0] tw_k(input logic [STAGE_W-1:0] s,
                                            input logic [BFLY_W-1:0]  b);
        logic [K_W-1:0] k;
        case (s)
            2'd0:    k = 2'd0;
            2'd1:    k = {b[0], 1'b0};
            default: k = b;
        endcase
        return k;
    endfunction

    function automatic logic [IDX_W-1:0] idx_top_f(input logic [STAGE_W-1:0] s,
                                                   input logic [BFLY_W-1:0]  b);
        logic [IDX_W-1:0] t;
        case (s)
            2'd0:    t = {b, 1'b0};
            2'd1:    t = {b[1], 1'b0, b[0]};
            default: t = {1'b0, b};
        endcase
        return t;
    endfunction

    function automatic logic [IDX_W-1:0] idx_bot_f(input logic [STAGE_W-1:0] s,
                                                   input logic [BFLY_W-1:0]  b);
        logic [IDX_W-1:0] span;
        case (s)
            2'd0:    span = 3'd1;
            2'd1:    span = 3'd2;
            default: span = 3'd4;
        endcase
        return idx_top_f(s, b) + span;
    endfunction

endpackage

// File: rtl/fft8_twiddle_rom.sv
// Combinational twiddle lookup: k plus inverse flag to Q8.8 real/imag pair.
// Inverse mode negates the imaginary part; no table entry is -0x8000 so negation never overflows.
module fft8_twiddle_rom
    import fft8_twiddle_seq_pkg::*;
(
    input  logic [K_W-1:0] k,
    input  logic           inverse,
    output q88_t           w_real,
    output q88_t           w_imag
);

    q88_t im_tab;

    always_comb begin
        w_real = TW0_RE;
        im_tab = TW0_IM;
        case (k)
            2'd0: begin w_real = TW0_RE; im_tab = TW0_IM; end
            2'd1: begin w_real = TW1_RE; im_tab = TW1_IM; end
            2'd2: begin w_real = TW2_RE; im_tab = TW2_IM; end
            default: begin w_real = TW3_RE; im_tab = TW3_IM; end
        endcase
        w_imag = inverse ? -im_tab : im_tab;
    end

endmodule

// File: rtl/fft8_twiddle_seq.sv
// Walks 3 stages x 4 butterflies of an 8-point DIT FFT, emitting one registered twiddle beat per butterfly.
// Optional TWSEQ_ADDR_EN adds registered idx_top/idx_bot butterfly addresses aligned with each beat.
module fft8_twiddle_seq #(
    parameter int W_WIDTH = 16,
    parameter int LOG2N   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               inverse,
    output logic               busy,
    output logic               tw_valid,
    input  logic               tw_ready,
    output logic [W_WIDTH-1:0] W_real,
    output logic [W_WIDTH-1:0] W_imag,
    output logic [1:0]         tw_stage,
    output logic [1:0]         tw_bfly,
    output logic               tw_last,
`ifdef TWSEQ_ADDR_EN
    output logic [2:0]         idx_top,
    output logic [2:0]         idx_bot,
`endif
    output logic               done
);

    import fft8_twiddle_seq_pkg::*;

    if (LOG2N != 3) begin : g_bad_log2n
        $error("fft8_twiddle_seq: LOG2N must be 3");
    end

    state_t               state;
    state_t               state_nxt;
    logic                 load;
    logic [STAGE_W-1:0]   stage_nxt;
    logic [BFLY_W-1:0]    bfly_nxt;
    logic                 last_nxt;
    logic                 inv_q;
    logic                 inv_nxt;
    logic [K_W-1:0]       k_nxt;
    q88_t                 rom_re;
    q88_t                 rom_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // tw_stage/tw_bfly double as the walk counters; load marks every edge a new beat is presented
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        stage_nxt = tw_stage;
        bfly_nxt  = tw_bfly;
        inv_nxt   = inv_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                    stage_nxt = 2'd0;
                    bfly_nxt  = 2'd0;
                    inv_nxt   = inverse;
                end
            end
            RUN: begin
                if (tw_ready) begin
                    if (tw_last) begin
                        state_nxt = DONE;
                    end else begin
                        load     = 1'b1;
                        bfly_nxt = tw_bfly + 2'd1;
                        if (tw_bfly == 2'd3) begin
                            stage_nxt = tw_stage + 2'd1;
                        end
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign last_nxt = (stage_nxt == 2'd2) && (bfly_nxt == 2'd3);
    assign k_nxt    = tw_k(stage_nxt, bfly_nxt);

    fft8_twiddle_rom u_rom (
        .k       (k_nxt),
        .inverse (inv_nxt),
        .w_real  (rom_re),
        .w_imag  (rom_im)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tw_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            inv_q    <= 1'b0;
            tw_stage <= '0;
            tw_bfly  <= '0;
            tw_last  <= 1'b0;
            W_real   <= '0;
            W_imag   <= '0;
        end else begin
            tw_valid <= (state_nxt == RUN);
            busy     <= (state_nxt != IDLE);
            done     <= (state_nxt == DONE);
            inv_q    <= inv_nxt;
            if (load) begin
                tw_stage <= stage_nxt;
                tw_bfly  <= bfly_nxt;
                tw_last  <= last_nxt;
                W_real   <= W_WIDTH'(rom_re);
                W_imag   <= W_WIDTH'(rom_im);
            end else if (state_nxt != RUN) begin
                tw_last  <= 1'b0;
            end
        end
    end

`ifdef TWSEQ_ADDR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_top <= '0;
            idx_bot <= '0;
        end else if (load) begin
            idx_top <= idx_top_f(stage_nxt, bfly_nxt);
            idx_bot <= idx_bot_f(stage_nxt, bfly_nxt);
        end
    end
`endif

endmodule

// File: tb/tb_fft8_twiddle_seq.sv
// Scoreboard bench for fft8_twiddle_seq: directed frames push hand-computed beats, a monitor pops on each transfer.
module tb_fft8_twiddle_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        inverse;
    logic        busy;
    logic        tw_valid;
    logic        tw_ready;
    logic [15:0] W_real;
    logic [15:0] W_imag;
    logic [1:0]  tw_stage;
    logic [1:0]  tw_bfly;
    logic        tw_last;
    logic        done;
`ifdef TWSEQ_ADDR_EN
    logic [2:0]  idx_top;
    logic [2:0]  idx_bot;
`endif

    fft8_twiddle_seq #(.W_WIDTH(16), .LOG2N(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .inverse  (inverse),
        .busy     (busy),
        .tw_valid (tw_valid),
        .tw_ready (tw_ready),
        .W_real   (W_real),
        .W_imag   (W_imag),
        .tw_stage (tw_stage),
        .tw_bfly  (tw_bfly),
        .tw_last  (tw_last),
`ifdef TWSEQ_ADDR_EN
        .idx_top  (idx_top),
        .idx_bot  (idx_bot),
`endif
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic [1:0]  st;
        logic [1:0]  bf;
        logic        last;
        logic [2:0]  top;
        logic [2:0]  bot;
    } beat_t;

    beat_t q[$];

    // Hand-computed beats in issue order: s0 b0..3, s1 b0..3, s2 b0..3
    logic [15:0] fwd_re [12] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100,
                                 16'h0100, 16'h0000, 16'h0100, 16'h0000,
                                 16'h0100, 16'h00B5, 16'h0000, 16'hFF4B};
    logic [15:0] fwd_im [12] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                 16'h0000, 16'hFF00, 16'h0000, 16'hFF00,
                                 16'h0000, 16'hFF4B, 16'hFF00, 16'hFF4B};
    logic [15:0] inv_im [12] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                 16'h0000, 16'h0100, 16'h0000, 16'h0100,
                                 16'h0000, 16'h00B5, 16'h0100, 16'h00B5};
    logic [2:0]  e_top  [12] = '{3'd0, 3'd2, 3'd4, 3'd6,
                                 3'd0, 3'd1, 3'd4, 3'd5,
                                 3'd0, 3'd1, 3'd2, 3'd3};
    logic [2:0]  e_bot  [12] = '{3'd1, 3'd3, 3'd5, 3'd7,
                                 3'd2, 3'd3, 3'd6, 3'd7,
                                 3'd4, 3'd5, 3'd6, 3'd7};

    task automatic push_frame(input bit inv, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.re   = fwd_re[i];
            b.im   = inv ? inv_im[i] : fwd_im[i];
            b.st   = 2'(i / 4);
            b.bf   = 2'(i % 4);
            b.last = (i == 11);
            b.top  = e_top[i];
            b.bot  = e_bot[i];
            q.push_back(b);
        end
    endtask

    int    cyc      = 0;
    int    done_cnt = 0;
    int    last_cyc = -100;
    beat_t e;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (tw_valid && tw_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", {30'd0, tw_stage}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("beat_real",  {16'd0, W_real}, {16'd0, e.re});
                    chk("beat_imag",  {16'd0, W_imag}, {16'd0, e.im});
                    chk("beat_stage", {30'd0, tw_stage}, {30'd0, e.st});
                    chk("beat_bfly",  {30'd0, tw_bfly}, {30'd0, e.bf});
                    chk("beat_last",  {31'd0, tw_last}, {31'd0, e.last});
`ifdef TWSEQ_ADDR_EN
                    chk("beat_idx_top", {29'd0, idx_top}, {29'd0, e.top});
                    chk("beat_idx_bot", {29'd0, idx_bot}, {29'd0, e.bot});
`endif
                    if (e.last) last_cyc = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_latency", cyc - last_cyc, 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit inv);
        start   = 1'b1;
        inverse = inv;
        tick();
        start   = 1'b0;
        inverse = ~inv;
        chk("first_beat_valid", {31'd0, tw_valid}, 32'd1);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_beat(input logic [1:0] s, input logic [1:0] b, input string name);
        int n = 0;
        while (!(tw_valid && tw_stage == s && tw_bfly == b) && n < 40) begin
            tick();
            n++;
        end
        chk(name, {31'd0, tw_valid}, 32'd1);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        start    = 1'b0;
        inverse  = 1'b0;
        tw_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tw_valid", {31'd0, tw_valid}, 32'd0);
        chk("rst_busy",     {31'd0, busy}, 32'd0);
        chk("rst_done",     {31'd0, done}, 32'd0);
        chk("rst_W_real",   {16'd0, W_real}, 32'd0);
        chk("rst_W_imag",   {16'd0, W_imag}, 32'd0);
        chk("rst_stage",    {30'd0, tw_stage}, 32'd0);
        chk("rst_bfly",     {30'd0, tw_bfly}, 32'd0);
        chk("rst_last",     {31'd0, tw_last}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Forward frame, ready held high: busy spans start-accept through done
        push_frame(1'b0, 12);
        do_start(1'b0);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        chk("fwd_busy_cycles", n, 32'd13);
        chk("fwd_queue_empty", q.size(), 32'd0);
        chk("fwd_done_count", done_cnt, 32'd1);
        chk("fwd_valid_low", {31'd0, tw_valid}, 32'd0);

        // Inverse frame
        push_frame(1'b1, 12);
        do_start(1'b1);
        wait_idle("inv_idle_timeout");
        chk("inv_queue_empty", q.size(), 32'd0);
        chk("inv_done_count", done_cnt, 32'd2);

        // Stall for 5 cycles on stage1 bfly2
        push_frame(1'b0, 12);
        do_start(1'b0);
        wait_beat(2'd1, 2'd2, "stall_reach_s1b2");
        tw_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {31'd0, tw_valid}, 32'd1);
            chk("stall_real",  {16'd0, W_real}, 32'h0100);
            chk("stall_imag",  {16'd0, W_imag}, 32'h0000);
            chk("stall_stage", {30'd0, tw_stage}, 32'd1);
            chk("stall_bfly",  {30'd0, tw_bfly}, 32'd2);
        end
        tw_ready = 1'b1;
        wait_idle("stall_idle_timeout");
        chk("stall_queue_empty", q.size(), 32'd0);
        chk("stall_done_count", done_cnt, 32'd3);

        // start pulses in RUN and in DONE are ignored
        push_frame(1'b0, 12);
        do_start(1'b0);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("ign_done_seen", {31'd0, done}, 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ign_busy_low", {31'd0, busy}, 32'd0);
            chk("ign_valid_low", {31'd0, tw_valid}, 32'd0);
        end
        chk("ign_queue_empty", q.size(), 32'd0);
        chk("ign_done_count", done_cnt, 32'd4);

        // Reset asserted while stage1 bfly0 is presented
        push_frame(1'b0, 4);
        do_start(1'b0);
        wait_beat(2'd1, 2'd0, "abort_reach_s1b0");
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, tw_valid}, 32'd0);
        chk("abort_busy",  {31'd0, busy}, 32'd0);
        chk("abort_real",  {16'd0, W_real}, 32'd0);
        chk("abort_imag",  {16'd0, W_imag}, 32'd0);
        chk("abort_stage", {30'd0, tw_stage}, 32'd0);
        chk("abort_bfly",  {30'd0, tw_bfly}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("abort_no_done", done_cnt, 32'd4);
        chk("abort_queue_empty", q.size(), 32'd0);

        push_frame(1'b0, 12);
        do_start(1'b0);
        chk("restart_stage", {30'd0, tw_stage}, 32'd0);
        chk("restart_bfly",  {30'd0, tw_bfly}, 32'd0);
        wait_idle("restart_idle_timeout");
        chk("restart_queue_empty", q.size(), 32'd0);
        chk("restart_done_count", done_cnt, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
